// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MA-stage data-bus engine: direction codes, access sizes, FSM states.
// The MISALIGN_TRAP_EN build option is consumed by mem_access_unit.sv; this package is unaffected by it.
package mem_access_unit_pkg;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_RD   = 2'b01;
    localparam logic [1:0] DIR_WR   = 2'b10;

    localparam logic [2:0] SZ_BYTE  = 3'b000;
    localparam logic [2:0] SZ_HALF  = 3'b010;
    localparam logic [2:0] SZ_WORD  = 3'b100;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    function automatic logic is_valid_access(input logic [1:0] wrn, input logic [2:0] size);
        logic dir_ok;
        logic size_ok;
        dir_ok  = (wrn == DIR_WR) || (wrn == DIR_RD);
        size_ok = (size == SZ_BYTE) || (size == SZ_HALF) || (size == SZ_WORD);
        return dir_ok && size_ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for a 4-lane data bus: byte enables, store replication,
// load extract/extend, and misalignment detection. Addresses are forced to natural alignment.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_ext,
    output logic [1:0]  aligned_lo,
    output logic        misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        aligned_lo = addr_lo;
        misalign   = 1'b0;
        be         = 4'b0000;
        wdata_lane = wdata;
        load_ext   = rdata;
        byte_v     = 8'h00;
        half_v     = 16'h0000;
        case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                byte_v     = rdata[{addr_lo, 3'b000} +: 8];
                load_ext   = {{24{sign_ext & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                aligned_lo = {addr_lo[1], 1'b0};
                misalign   = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                half_v     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
                load_ext   = {{16{sign_ext & half_v[15]}}, half_v};
            end
            SZ_WORD: begin
                aligned_lo = 2'b00;
                misalign   = |addr_lo;
                be         = 4'b1111;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MA-stage data-bus engine: req/ack bus transaction with pipeline stall and extended load return.
// Build option MISALIGN_TRAP_EN: misaligned accesses are trapped instead of force-aligned.
//
// state   | meaning
// IDLE    | waiting for a valid access; latches bus fields on accept
// REQ     | mem_req high, bus fields stable, waiting for mem_ack
// RESP    | one-cycle completion; pipeline advances, load_valid_WB for reads
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      wrn_MA,
    input  logic [2:0]      num_bytes_MA,
    input  logic            signado_MA,
    input  logic [XLEN-1:0] addr_MA,
    input  logic [XLEN-1:0] wdata_MA,
    output logic            stall_MA,
    output logic [XLEN-1:0] load_data_WB,
    output logic            load_valid_WB,
    output logic            misalign_MA,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

`ifdef MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic [1:0]      state;
    logic [2:0]      size_q;
    logic            sign_q;
    logic [1:0]      lo_q;
    logic            misalign_q;
    logic            acc_valid;

    logic [2:0]      al_size;
    logic            al_sign;
    logic [1:0]      al_lo_in;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_load;
    logic [1:0]      al_lo;
    logic            al_misalign;

    assign acc_valid = is_valid_access(wrn_MA, num_bytes_MA);
    assign stall_MA  = ((state == ST_IDLE) && acc_valid) || (state == ST_REQ);
    assign mem_req   = (state == ST_REQ);
    assign misalign_MA = TRAP_EN & misalign_q;

    // Lane logic sees the live MA inputs while accepting, then the latched access for load extract.
    assign al_size  = (state == ST_IDLE) ? num_bytes_MA : size_q;
    assign al_sign  = (state == ST_IDLE) ? signado_MA   : sign_q;
    assign al_lo_in = (state == ST_IDLE) ? addr_MA[1:0] : lo_q;

    mem_lane_align u_lane_align (
        .size       (al_size),
        .sign_ext   (al_sign),
        .addr_lo    (al_lo_in),
        .wdata      (wdata_MA),
        .rdata      (mem_rdata),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .load_ext   (al_load),
        .aligned_lo (al_lo),
        .misalign   (al_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_be        <= 4'b0000;
            mem_wdata     <= '0;
            load_data_WB  <= '0;
            load_valid_WB <= 1'b0;
            misalign_q    <= 1'b0;
            size_q        <= SZ_BYTE;
            sign_q        <= 1'b0;
            lo_q          <= 2'b00;
        end else begin
            load_valid_WB <= 1'b0;
            misalign_q    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (acc_valid) begin
                        if (TRAP_EN && al_misalign) begin
                            misalign_q <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            mem_addr  <= {addr_MA[XLEN-1:2], 2'b00};
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
                            mem_we    <= wrn_MA[1];
                            size_q    <= num_bytes_MA;
                            sign_q    <= signado_MA;
                            lo_q      <= al_lo;
                            state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            load_data_WB  <= al_load;
                            load_valid_WB <= 1'b1;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
